// File: rtl/fft_stage_ctrl_if.sv
// fft_stage_ctrl_if
// Complex sample stream: one val/rdy handshake carrying a real and an
// imaginary word. The controller uses one instance for its input samples
// and one for its output samples.
//   val  - producer has a sample on r/c
//   rdy  - consumer accepts the sample this cycle
//   r, c - real and imaginary components, n bits each
interface fft_stage_ctrl_if #(
    parameter int n = 32
);
    logic         val;
    logic         rdy;
    logic [n-1:0] r;
    logic [n-1:0] c;

    modport master (output val, r, c, input rdy);
    modport slave  (input val, r, c, output rdy);
endinterface

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl
// Sequencer for one radix-2 FFT stage around a single shared butterfly.
// It loads N complex samples into a buffer, issues the N/2 butterflies of
// the selected stage one at a time (twiddle address to an external ROM,
// results written back in place), then streams the frame out in index order.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   recv (slave)        - input sample stream
//   stage               - stage select, sampled on the last input beat
//   send (master)       - output sample stream
//   tw_idx, tw_r/tw_c   - twiddle ROM address and its combinational data
//   bf_recv_val/rdy     - butterfly issue handshake, operands bf_a*/bf_b*/bf_w*
//   bf_send_val/rdy     - butterfly result handshake, results bf_c*/bf_d*
module fft_stage_ctrl #(
    parameter int n = 32,
    parameter int d = 16,
    parameter int N = 8,
    localparam int LW = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    fft_stage_ctrl_if.slave   recv,
    input  logic [LW-1:0]     stage,
    fft_stage_ctrl_if.master  send,
    output logic [LW-2:0]     tw_idx,
    input  logic [n-1:0]      tw_r,
    input  logic [n-1:0]      tw_c,
    output logic              bf_recv_val,
    input  logic              bf_recv_rdy,
    output logic [n-1:0]      bf_ar,
    output logic [n-1:0]      bf_ac,
    output logic [n-1:0]      bf_br,
    output logic [n-1:0]      bf_bc,
    output logic [n-1:0]      bf_wr,
    output logic [n-1:0]      bf_wc,
    input  logic              bf_send_val,
    output logic              bf_send_rdy,
    input  logic [n-1:0]      bf_cr,
    input  logic [n-1:0]      bf_cc,
    input  logic [n-1:0]      bf_dr,
    input  logic [n-1:0]      bf_dc
);
    // The fractional width only matters to the butterfly; reject nonsense.
    if (d >= n) begin : g_bad_frac
        $error("fft_stage_ctrl: d must be smaller than n");
    end

    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} state_t;

    localparam logic [LW-1:0] K_ONE     = LW'(1);
    localparam logic [LW-1:0] K_LAST    = LW'(N - 1);
    localparam logic [LW-1:0] K_BF_LAST = LW'(N / 2 - 1);
    localparam logic [LW-1:0] S_MAX     = LW'(LW - 1);

    state_t             state, state_nxt;
    logic [LW-1:0]      k;          // sample / butterfly index, shared by all states
    logic [LW-1:0]      s_log;      // log2 of butterfly span S for this frame
    logic [LW-1:0]      s_val;
    logic [LW-1:0]      lo_mask;
    logic [LW-1:0]      idx_i;
    logic [LW-1:0]      idx_j;
    logic [LW-1:0]      stage_clamp;
    logic [2*n-1:0]     mem [N];

    // Out-of-range stages behave as the last stage.
    assign stage_clamp = (stage > S_MAX) ? S_MAX : stage;

    // S is a power of two, so (k/S)*2S + k%S is "insert a zero bit at
    // position log2(S)" and j = i + S just sets that bit.
    assign s_val   = K_ONE << s_log;
    assign lo_mask = s_val - K_ONE;
    assign idx_i   = ((k & ~lo_mask) << 1) | (k & lo_mask);
    assign idx_j   = idx_i | s_val;

    // (k mod S) * N/(2S): k mod S < N/2, so it fits the ROM address width.
    assign tw_idx = (LW-1)'(k & lo_mask) << (S_MAX - s_log);

    assign {bf_ar, bf_ac} = mem[idx_i];
    assign {bf_br, bf_bc} = mem[idx_j];
    assign bf_wr          = tw_r;
    assign bf_wc          = tw_c;
    assign {send.r, send.c} = mem[k];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            k     <= '0;
            s_log <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                LOAD: if (recv.val) begin
                    k <= (k == K_LAST) ? '0 : k + K_ONE;
                    if (k == K_LAST) s_log <= stage_clamp;
                end
                WAIT: if (bf_send_val) begin
                    k <= (k == K_BF_LAST) ? '0 : k + K_ONE;
                end
                DRAIN: if (send.rdy) begin
                    k <= (k == K_LAST) ? '0 : k + K_ONE;
                end
                default: ;
            endcase
        end
    end

    // Sample buffer is not reset; a result arriving during reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == LOAD && recv.val) begin
                mem[k] <= {recv.r, recv.c};
            end
            if (state == WAIT && bf_send_val) begin
                mem[idx_i] <= {bf_cr, bf_cc};
                mem[idx_j] <= {bf_dr, bf_dc};
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        recv.rdy    = 1'b0;
        send.val    = 1'b0;
        bf_recv_val = 1'b0;
        bf_send_rdy = 1'b0;
        case (state)
            LOAD: begin
                recv.rdy = 1'b1;
                if (recv.val && k == K_LAST) state_nxt = ISSUE;
            end
            ISSUE: begin
                bf_recv_val = 1'b1;
                if (bf_recv_rdy) state_nxt = WAIT;
            end
            WAIT: begin
                bf_send_rdy = 1'b1;
                if (bf_send_val) state_nxt = (k == K_BF_LAST) ? DRAIN : ISSUE;
            end
            DRAIN: begin
                send.val = 1'b1;
                if (send.rdy && k == K_LAST) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb_fft_stage_ctrl
// Scoreboard bench: each frame pushes its expected twiddle addresses and
// output samples into queues; a butterfly model and an output monitor pop
// and compare as the DUT presents them.
module tb_fft_stage_ctrl;
    localparam int n  = 32;
    localparam int d  = 16;
    localparam int N  = 8;
    localparam int LW = 3;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fft_stage_ctrl_if #(.n(n)) recv ();
    fft_stage_ctrl_if #(.n(n)) send ();

    logic [LW-1:0] stage;
    logic [LW-2:0] tw_idx;
    logic [n-1:0]  tw_r, tw_c;
    logic          bf_recv_val, bf_recv_rdy, bf_send_val, bf_send_rdy;
    logic [n-1:0]  bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc;
    logic [n-1:0]  bf_cr, bf_cc, bf_dr, bf_dc;

    fft_stage_ctrl #(.n(n), .d(d), .N(N)) dut (
        .clk(clk), .reset(reset), .recv(recv), .stage(stage), .send(send),
        .tw_idx(tw_idx), .tw_r(tw_r), .tw_c(tw_c),
        .bf_recv_val(bf_recv_val), .bf_recv_rdy(bf_recv_rdy),
        .bf_ar(bf_ar), .bf_ac(bf_ac), .bf_br(bf_br), .bf_bc(bf_bc),
        .bf_wr(bf_wr), .bf_wc(bf_wc),
        .bf_send_val(bf_send_val), .bf_send_rdy(bf_send_rdy),
        .bf_cr(bf_cr), .bf_cc(bf_cc), .bf_dr(bf_dr), .bf_dc(bf_dc)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    int          exp_tw[$];
    logic [63:0] x[N];
    logic [63:0] g[N];

    bit tw_mode  = 1'b0;
    bit send_rand = 1'b0;
    int lat_lo = 1, lat_hi = 1, hold_hi = 0;
    int acc_cnt = 0;
    bit bf_busy = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    function automatic logic [63:0] rom(input int t);
        if (!tw_mode) return {ONE, 32'h0};
        case (t)
            0:       return {ONE, 32'h0};
            1:       return {32'h0000B505, 32'hFFFF4AFB};
            2:       return {32'h0, 32'hFFFF0000};
            default: return {32'hFFFF4AFB, 32'hFFFF4AFB};
        endcase
    endfunction

    assign {tw_r, tw_c} = rom(int'(tw_idx));

    // c = a + w*b, d = a - w*b in Q(d) fixed point, wrapping to n bits.
    task automatic bfly(input logic [63:0] a, input logic [63:0] b, input logic [63:0] w,
                        output logic [63:0] c, output logic [63:0] dd);
        longint ar, ac, br, bc, wr, wc, pr, pc;
        ar = longint'(signed'(a[63:32])); ac = longint'(signed'(a[31:0]));
        br = longint'(signed'(b[63:32])); bc = longint'(signed'(b[31:0]));
        wr = longint'(signed'(w[63:32])); wc = longint'(signed'(w[31:0]));
        pr = (wr * br - wc * bc) >>> d;
        pc = (wr * bc + wc * br) >>> d;
        c  = {32'(ar + pr), 32'(ac + pc)};
        dd = {32'(ar - pr), 32'(ac - pc)};
    endtask

    task automatic golden(input int st);
        int s, i, j, t;
        logic [63:0] c, dd;
        s = 1 << ((st > LW - 1) ? LW - 1 : st);
        for (int m = 0; m < N; m++) g[m] = x[m];
        for (int k = 0; k < N / 2; k++) begin
            i = (k / s) * 2 * s + k % s;
            j = i + s;
            t = (k % s) * (N / (2 * s));
            exp_tw.push_back(t);
            bfly(g[i], g[j], rom(t), c, dd);
            g[i] = c;
            g[j] = dd;
        end
        for (int m = 0; m < N; m++) exp_q.push_back(g[m]);
    endtask

    task automatic ramp_frame();
        for (int i = 0; i < N; i++) x[i] = {32'(i * 65536), 32'h0};
    endtask

    task automatic rand_frame();
        for (int i = 0; i < N; i++)
            x[i] = {32'($urandom_range(0, 2097151)) - 32'd1048576,
                    32'($urandom_range(0, 2097151)) - 32'd1048576};
    endtask

    task automatic push_hand(input int r0, input int r1, input int r2, input int r3,
                             input int r4, input int r5, input int r6, input int r7);
        int hr[8];
        hr = '{r0, r1, r2, r3, r4, r5, r6, r7};
        for (int i = 0; i < N; i++) exp_q.push_back({32'(hr[i] * 65536), 32'h0});
    endtask

    // stage carries junk except on the last beat, where it is sampled.
    task automatic load_frame(input int st, input int gap_hi);
        bit fired;
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, gap_hi)) begin
                recv.val = 1'b0;
                @(posedge clk); #1;
            end
            recv.val = 1'b1;
            recv.r   = x[i][63:32];
            recv.c   = x[i][31:0];
            stage    = (i == N - 1) ? LW'(st) : LW'($urandom_range(0, 7));
            fired = 1'b0;
            for (int c = 0; c < 200 && !fired; c++) begin
                @(negedge clk);
                fired = recv.rdy;
                @(posedge clk); #1;
            end
            if (!fired) begin
                checks++; errors++;
                $display("FAIL load_timeout: beat %0d not accepted, required within 200 cycles", i);
            end
        end
        recv.val = 1'b0;
    endtask

    task automatic wait_empty();
        for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d outputs missing, required 0", exp_q.size());
            exp_q.delete();
            exp_tw.delete();
        end
        @(posedge clk); #1;
    endtask

    // send_rdy driver
    initial begin
        send.rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            send.rdy = send_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Butterfly model plus issue-side checks.
    logic [194:0] prev_ops;
    bit op_stall = 1'b0;
    initial begin : bfm
        logic acc, done, rs;
        logic [63:0] c, dd;
        int cnt, hold;
        cnt = 0; hold = 0; c = '0; dd = '0;
        bf_recv_rdy = 1'b1; bf_send_val = 1'b0;
        {bf_cr, bf_cc, bf_dr, bf_dc} = '0;
        forever begin
            @(negedge clk);
            rs   = reset;
            acc  = bf_recv_val && bf_recv_rdy;
            done = bf_send_val && bf_send_rdy;
            if (!rs) begin
                if (bf_busy) check("bf_one_issue", 64'(bf_recv_val), 64'd0);
                if (op_stall) begin
                    checks++;
                    if (!bf_recv_val || {bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc, tw_idx} !== prev_ops) begin
                        errors++;
                        $display("FAIL bf_ops_stable: val %0b ops changed during stall", bf_recv_val);
                    end
                end
                op_stall = bf_recv_val && !bf_recv_rdy;
                prev_ops = {bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc, tw_idx};
                if (acc) begin
                    if (exp_tw.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bf_extra_issue: tw_idx %0d, required no issue", tw_idx);
                    end else check("tw_idx", 64'(tw_idx), 64'(exp_tw.pop_front()));
                    bfly({bf_ar, bf_ac}, {bf_br, bf_bc}, {bf_wr, bf_wc}, c, dd);
                end
            end else op_stall = 1'b0;
            @(posedge clk); #1;
            if (rs) begin
                bf_busy = 1'b0; bf_send_val = 1'b0; bf_recv_rdy = 1'b1;
            end else if (done) begin
                bf_send_val = 1'b0; bf_busy = 1'b0;
                hold = $urandom_range(0, hold_hi);
                bf_recv_rdy = (hold == 0);
            end else if (acc) begin
                bf_busy = 1'b1; acc_cnt++; bf_recv_rdy = 1'b0;
                {bf_cr, bf_cc} = c;
                {bf_dr, bf_dc} = dd;
                cnt = $urandom_range(lat_lo, lat_hi) - 1;
                bf_send_val = (cnt == 0);
            end else if (bf_busy && !bf_send_val) begin
                cnt--;
                bf_send_val = (cnt == 0);
            end else if (!bf_busy && !bf_recv_rdy) begin
                hold--;
                bf_recv_rdy = (hold <= 0);
            end
        end
    end

    // Output monitor: scoreboard pop, hold under stall, no recv_rdy while busy.
    int  rcnt = 0, scnt = 0;
    bit  fr_busy = 1'b0, s_stall = 1'b0;
    logic [63:0] s_held;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                rcnt = 0; scnt = 0; fr_busy = 1'b0; s_stall = 1'b0;
            end else begin
                if (fr_busy) check("recv_rdy_busy", 64'(recv.rdy), 64'd0);
                if (s_stall) begin
                    check("send_hold_val", 64'(send.val), 64'd1);
                    check("send_hold_data", {send.r, send.c}, s_held);
                end
                s_stall = send.val && !send.rdy;
                s_held  = {send.r, send.c};
                if (recv.val && recv.rdy) begin
                    rcnt++;
                    if (rcnt == N) begin fr_busy = 1'b1; rcnt = 0; end
                end
                if (send.val && send.rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL send_extra: got %h, required no output", {send.r, send.c});
                    end else check("send_data", {send.r, send.c}, exp_q.pop_front());
                    scnt++;
                    if (scnt == N) begin fr_busy = 1'b0; scnt = 0; end
                end
            end
        end
    end

    initial begin
        #500000;
        checks++; errors++;
        $display("FAIL watchdog: time limit reached, required finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        recv.val = 1'b0; recv.r = '0; recv.c = '0; stage = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_recv_rdy", 64'(recv.rdy), 64'd1);
        check("rst_send_val", 64'(send.val), 64'd0);
        check("rst_bf_recv_val", 64'(bf_recv_val), 64'd0);
        check("rst_bf_send_rdy", 64'(bf_send_rdy), 64'd0);
        @(posedge clk); #1;

        // Stage 0, unit twiddles, ramp input.
        tw_mode = 1'b0;
        ramp_frame();
        for (int i = 0; i < 4; i++) exp_tw.push_back(0);
        push_hand(1, -1, 5, -1, 9, -1, 13, -1);
        load_frame(0, 0);
        wait_empty();

        // Stage 2 and out-of-range stage 7 give the same hand result.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) exp_tw.push_back(i);
            push_hand(4, 6, 8, 10, -4, -4, -4, -4);
            load_frame(r == 0 ? 2 : 7, 0);
            wait_empty();
        end

        // Random butterfly latency and issue backpressure, real twiddles.
        tw_mode = 1'b1; lat_lo = 1; lat_hi = 10; hold_hi = 3;
        for (int st = 0; st < 3; st++) begin
            rand_frame(); golden(st); load_frame(st, 0); wait_empty();
        end

        // Random output backpressure and input gaps.
        send_rand = 1'b1;
        rand_frame(); golden(2); load_frame(2, 3); wait_empty();
        rand_frame(); golden(5); load_frame(5, 3); wait_empty();

        // Reset during WAIT of butterfly 2.
        send_rand = 1'b0; lat_lo = 4; lat_hi = 4; hold_hi = 0;
        rand_frame(); golden(1);
        acc_cnt = 0;
        load_frame(1, 0);
        for (int c = 0; c < 500 && !(acc_cnt == 3 && bf_busy && !bf_send_val); c++) @(negedge clk);
        check("mid_wait_reached", 64'(acc_cnt == 3 && bf_busy), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        exp_q.delete(); exp_tw.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_recv_rdy", 64'(recv.rdy), 64'd1);
        check("mid_rst_send_val", 64'(send.val), 64'd0);
        check("mid_rst_bf_recv_val", 64'(bf_recv_val), 64'd0);
        @(posedge clk); #1;

        // Fresh frame after the abandoned one.
        send_rand = 1'b1; lat_lo = 1; lat_hi = 6; hold_hi = 2;
        rand_frame(); golden(0); load_frame(0, 2); wait_empty();
        send_rand = 1'b0;
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
